// File: rtl/gf163_inverter_if.sv
`default_nettype none
// ============================================================================
//  Module   : gf163_inverter_if
//  Brief    : Request/result bundle for the GF(2^163) inverter.
//  Revision : 1.0 - initial release
// ============================================================================
interface gf163_inverter_if;
    logic         start;
    logic [162:0] a;
    logic         busy;
    logic         done;
    logic [162:0] z;
    logic         err;

    modport master (
        output start,
        output a,
        input  busy,
        input  done,
        input  z,
        input  err
    );

    modport slave (
        input  start,
        input  a,
        output busy,
        output done,
        output z,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/gf163_inverter.sv
`default_nettype none
// ============================================================================
//  Module   : gf163_inverter
//  Brief    : Sequential GF(2^163) inverter, binary extended Euclid, one step
//             per clock. f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//  Revision : 1.0 - initial release
// ============================================================================
module gf163_inverter (
    input  logic            clk,
    input  logic            rst,
    gf163_inverter_if.slave bus
);

    localparam logic [0:0]   S_IDLE = 1'b0;
    localparam logic [0:0]   S_RUN  = 1'b1;

    localparam logic [163:0] c_poly      = {1'b1, 155'd0, 8'hC9};
    // f >> 1 (bits 162, 6, 5, 2): lets (g ^ f) >> 1 be formed as (g >> 1) ^ (f >> 1)
    localparam logic [162:0] c_poly_half = {1'b1, 155'd0, 7'h64};

    function automatic logic [162:0] f_halve(input logic [162:0] g);
        logic [162:0] w_shift;
        w_shift = {1'b0, g[162:1]};
        return g[0] ? (w_shift ^ c_poly_half) : w_shift;
    endfunction

    function automatic logic [7:0] f_deg(input logic [163:0] x);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 164; i++) begin
            if (x[i]) d = 8'(i);
        end
        return d;
    endfunction

    logic [0:0]   r_state;
    logic [163:0] r_u;
    logic [163:0] r_v;
    logic [162:0] r_g1;
    logic [162:0] r_g2;
    logic         r_zero_pend;
    logic         r_busy;
    logic         r_done;
    logic [162:0] r_z;
    logic         r_err;

    logic [7:0]   w_deg_u;
    logic [7:0]   w_deg_v;
    logic         w_u_one;
    logic         w_v_one;
    logic         w_u_gt_v;
    logic         w_a_zero;

    assign w_deg_u  = f_deg(r_u);
    assign w_deg_v  = f_deg(r_v);
    assign w_u_one  = (r_u == 164'd1);
    assign w_v_one  = (r_v == 164'd1);
    assign w_u_gt_v = (w_deg_u > w_deg_v);
    assign w_a_zero = (bus.a == 163'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_u         <= '0;
            r_v         <= '0;
            r_g1        <= '0;
            r_g2        <= '0;
            r_zero_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_z         <= '0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A zero operand is reported one edge after acceptance, matching the
            // latency of a=1, without ever entering RUN.
            if (r_zero_pend) begin
                r_zero_pend <= 1'b0;
                r_done      <= 1'b1;
                r_err       <= 1'b1;
                r_z         <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_a_zero) begin
                            r_zero_pend <= 1'b1;
                        end else begin
                            r_u     <= {1'b0, bus.a};
                            r_v     <= c_poly;
                            r_g1    <= 163'd1;
                            r_g2    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                            if (!r_zero_pend) r_err <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    if (w_u_one) begin
                        r_z     <= r_g1;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_v_one) begin
                        r_z     <= r_g2;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_u[0]) begin
                        r_u  <= {1'b0, r_u[163:1]};
                        r_g1 <= f_halve(r_g1);
                    end else if (!r_v[0]) begin
                        r_v  <= {1'b0, r_v[163:1]};
                        r_g2 <= f_halve(r_g2);
                    end else if (w_u_gt_v) begin
                        r_u  <= r_u ^ r_v;
                        r_g1 <= r_g1 ^ r_g2;
                    end else begin
                        r_v  <= r_v ^ r_u;
                        r_g2 <= r_g2 ^ r_g1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.z    = r_z;
    assign bus.err  = r_err;

endmodule
`default_nettype wire
